// File: rtl/smart_down_timer_if.sv
// smart_down_timer_if: control/status bundle of the loadable down-timer.
// master = the controller that arms the timer; slave = the timer itself.
// The prescale field exists only when SMART_DOWN_TIMER_PRESCALER_EN is defined.
interface smart_down_timer_if #(
  parameter int WIDTH = 8,
  parameter int EXP_W = 8
);
  logic             start;
  logic             stop;
  logic             pause;
  logic             periodic;
  logic [WIDTH-1:0] load_val;
`ifdef SMART_DOWN_TIMER_PRESCALER_EN
  logic [3:0]       prescale;
`endif
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             tc_pulse;
  logic [EXP_W-1:0] expire_cnt;

`ifdef SMART_DOWN_TIMER_PRESCALER_EN
  modport master (
    output start, stop, pause, periodic, load_val, prescale,
    input  count, busy, done, tc_pulse, expire_cnt
  );
  modport slave (
    input  start, stop, pause, periodic, load_val, prescale,
    output count, busy, done, tc_pulse, expire_cnt
  );
`else
  modport master (
    output start, stop, pause, periodic, load_val,
    input  count, busy, done, tc_pulse, expire_cnt
  );
  modport slave (
    input  start, stop, pause, periodic, load_val,
    output count, busy, done, tc_pulse, expire_cnt
  );
`endif
endinterface

// File: rtl/smart_down_timer.sv
// smart_down_timer: loadable down-counting timer with one-shot and periodic
// (auto-reload) modes, one-cycle expiry pulse and a saturating expiry counter.
// Input priority every cycle: stop > start > pause > tick.
// Optional feature macro: SMART_DOWN_TIMER_PRESCALER_EN adds a 4-bit prescaler
// so that one countdown step takes prescale+1 cycles in RUN.
module smart_down_timer #(
  parameter int WIDTH = 8,
  parameter int EXP_W = 8
) (
  input  logic                   clk,
  input  logic                   arst_n,
  smart_down_timer_if.slave      bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Expiry counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [EXP_W-1:0] sat_inc(input logic [EXP_W-1:0] v);
    logic [EXP_W-1:0] res;
    if (v == {EXP_W{1'b1}}) begin
      res = v;
    end else begin
      res = v + EXP_W'(1);
    end
    return res;
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] r_reload;
  logic [WIDTH-1:0] w_reload_nxt;
  logic             r_mode;
  logic             w_mode_nxt;
  logic             r_tc;
  logic             w_tc_nxt;
  logic [EXP_W-1:0] r_exp;
  logic [EXP_W-1:0] w_exp_nxt;

  logic             w_tick;
  logic             w_run_step;
  logic             w_expire;
  logic             w_load_zero;

  assign w_load_zero = (bus.load_val == {WIDTH{1'b0}});

`ifdef SMART_DOWN_TIMER_PRESCALER_EN
  logic [3:0] r_psc;
  logic [3:0] w_psc_nxt;

  assign w_tick = (r_psc == bus.prescale);

  // Prescale counter next value: cleared on stop/start, advances only while
  // actively counting in RUN, wraps on each tick, holds in PAUSE/IDLE/DONE.
  always_comb begin
    w_psc_nxt = r_psc;
    if (bus.stop || bus.start) begin
      w_psc_nxt = 4'd0;
    end else if ((r_state == ST_RUN) && !bus.pause) begin
      if (w_tick) begin
        w_psc_nxt = 4'd0;
      end else begin
        w_psc_nxt = r_psc + 4'd1;
      end
    end else begin
      w_psc_nxt = r_psc;
    end
  end

  // Prescale counter register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_psc <= 4'd0;
    end else begin
      r_psc <= w_psc_nxt;
    end
  end
`else
  assign w_tick = 1'b1;
`endif

  // A countdown step happens only in RUN when no higher-priority input is set.
  assign w_run_step = (r_state == ST_RUN) && !bus.stop && !bus.start &&
                      !bus.pause && w_tick;
  // Count 0 in RUN is unreachable in normal use; it is treated as an expiry
  // so the timer can never stall in RUN.
  assign w_expire   = w_run_step && (r_count <= WIDTH'(1));

  // State register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.stop) begin
      w_state_nxt = ST_IDLE;
    end else if (bus.start) begin
      // A zero load expires at once and never enters RUN, even in periodic mode.
      if (w_load_zero) begin
        w_state_nxt = ST_DONE;
      end else begin
        w_state_nxt = ST_RUN;
      end
    end else begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_IDLE;
        ST_RUN: begin
          if (bus.pause) begin
            w_state_nxt = ST_PAUSE;
          end else if (w_expire && !r_mode) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_PAUSE: begin
          if (bus.pause) begin
            w_state_nxt = ST_PAUSE;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_DONE:  w_state_nxt = ST_DONE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Datapath next values: count, reload, mode, expiry pulse and counter.
  always_comb begin
    w_count_nxt  = r_count;
    w_reload_nxt = r_reload;
    w_mode_nxt   = r_mode;
    w_exp_nxt    = r_exp;
    w_tc_nxt     = 1'b0;
    if (bus.stop) begin
      w_count_nxt = {WIDTH{1'b0}};
      w_exp_nxt   = {EXP_W{1'b0}};
      w_tc_nxt    = 1'b0;
    end else if (bus.start) begin
      w_reload_nxt = bus.load_val;
      w_count_nxt  = bus.load_val;
      w_mode_nxt   = bus.periodic;
      if (w_load_zero) begin
        w_tc_nxt  = 1'b1;
        w_exp_nxt = sat_inc(r_exp);
      end else begin
        w_tc_nxt  = 1'b0;
      end
    end else if (w_run_step) begin
      if (w_expire) begin
        w_tc_nxt  = 1'b1;
        w_exp_nxt = sat_inc(r_exp);
        if (r_mode) begin
          w_count_nxt = r_reload;
        end else begin
          w_count_nxt = {WIDTH{1'b0}};
        end
      end else begin
        w_count_nxt = r_count - WIDTH'(1);
      end
    end else begin
      w_count_nxt = r_count;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_count  <= {WIDTH{1'b0}};
      r_reload <= {WIDTH{1'b0}};
      r_mode   <= 1'b0;
      r_tc     <= 1'b0;
      r_exp    <= {EXP_W{1'b0}};
    end else begin
      r_count  <= w_count_nxt;
      r_reload <= w_reload_nxt;
      r_mode   <= w_mode_nxt;
      r_tc     <= w_tc_nxt;
      r_exp    <= w_exp_nxt;
    end
  end

  assign bus.count      = r_count;
  assign bus.tc_pulse   = r_tc;
  assign bus.expire_cnt = r_exp;
  assign bus.busy       = (r_state == ST_RUN) || (r_state == ST_PAUSE);
  assign bus.done       = (r_state == ST_DONE);

endmodule

// File: tb/tb_smart_down_timer.sv
// tb_smart_down_timer: directed stimulus with a tc_pulse scoreboard.
// The driver pushes the cycle and expire_cnt expected at each expiry; a
// monitor pops and compares whenever tc_pulse is seen.
module tb_smart_down_timer;
  localparam int WIDTH = 8;
  localparam int EXP_W = 8;

  typedef struct {
    int cyc;
    int exp;
  } ev_t;

  logic clk = 1'b0;
  logic arst_n;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  ev_t  exp_q[$];

  smart_down_timer_if #(.WIDTH(WIDTH), .EXP_W(EXP_W)) bus();

  smart_down_timer #(.WIDTH(WIDTH), .EXP_W(EXP_W)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  // Cycle counter: number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expect an expiry `off` edges after the upcoming start edge.
  task automatic push(input int off, input int e);
    ev_t ev;
    ev.cyc = cyc + 1 + off;
    ev.exp = e;
    exp_q.push_back(ev);
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
  endtask

  // Monitor: every tc_pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.tc_pulse === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_tc: pulse seen at cycle %0d, none expected", cyc);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("tc_cycle", cyc, e.cyc);
        chk("tc_expire_cnt", 32'(bus.expire_cnt), e.exp);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    arst_n       = 1'b0;
    bus.start    = 1'b1;
    bus.stop     = 1'b0;
    bus.pause    = 1'b0;
    bus.periodic = 1'b0;
    bus.load_val = 8'h05;
`ifdef SMART_DOWN_TIMER_PRESCALER_EN
    bus.prescale = 4'd0;
`endif
    // Reset with start held high.
    repeat (3) @(negedge clk);
    chk("rst_count_held", 32'(bus.count), 0);
    arst_n = 1'b1;
    #1;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_expire", 32'(bus.expire_cnt), 0);
    chk("rst_tc", 32'(bus.tc_pulse), 0);
    bus.start = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 0);

    // One-shot, load 5.
    bus.load_val = 8'd5; bus.periodic = 1'b0;
    push(5, 1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("os_count_start", 32'(bus.count), 5);
    chk("os_busy", 32'(bus.busy), 1);
    for (int i = 4; i >= 0; i--) begin
      @(negedge clk);
      chk("os_count", 32'(bus.count), i);
    end
    chk("os_done", 32'(bus.done), 1);
    chk("os_busy_after", 32'(bus.busy), 0);
    chk("os_expire", 32'(bus.expire_cnt), 1);
    @(negedge clk);
    chk("os_done_hold", 32'(bus.done), 1);
    chk("os_tc_low", 32'(bus.tc_pulse), 0);

    // Periodic, load 3, 12 cycles.
    pulse_stop();
    chk("stop_expire", 32'(bus.expire_cnt), 0);
    chk("stop_done", 32'(bus.done), 0);
    bus.load_val = 8'd3; bus.periodic = 1'b1;
    for (int k = 1; k <= 4; k++) push(3 * k, k);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      chk("per_count", 32'(bus.count), 3 - (j % 3));
      chk("per_done", 32'(bus.done), 0);
    end
    chk("per_expire", 32'(bus.expire_cnt), 4);
    chk("per_busy", 32'(bus.busy), 1);
    pulse_stop();
    chk("per_stop_count", 32'(bus.count), 0);
    chk("per_stop_expire", 32'(bus.expire_cnt), 0);
    chk("per_stop_busy", 32'(bus.busy), 0);

    // Pause at count 6, then re-arm with 2 at count 4.
    bus.load_val = 8'd10; bus.periodic = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pz_count_pre", 32'(bus.count), 6);
    bus.pause = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("pz_count_hold", 32'(bus.count), 6);
      chk("pz_busy", 32'(bus.busy), 1);
    end
    bus.pause = 1'b0;
    @(negedge clk);
    chk("pz_resume_edge", 32'(bus.count), 6);
    @(negedge clk);
    chk("pz_resume_5", 32'(bus.count), 5);
    @(negedge clk);
    chk("pz_resume_4", 32'(bus.count), 4);
    bus.load_val = 8'd2;
    push(2, 1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("rearm_count", 32'(bus.count), 2);
    @(negedge clk);
    chk("rearm_count_1", 32'(bus.count), 1);
    @(negedge clk);
    chk("rearm_count_0", 32'(bus.count), 0);
    chk("rearm_done", 32'(bus.done), 1);
    chk("rearm_expire", 32'(bus.expire_cnt), 1);

    // Load 0: immediate expiry into DONE even with periodic set.
    bus.load_val = 8'd0; bus.periodic = 1'b1;
    push(0, 2);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("zero_done", 32'(bus.done), 1);
    chk("zero_busy", 32'(bus.busy), 0);
    chk("zero_count", 32'(bus.count), 0);
    @(negedge clk);
    chk("zero_done_hold", 32'(bus.done), 1);

    // start and stop together: stop wins.
    bus.load_val = 8'd7;
    bus.start = 1'b1; bus.stop = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.stop = 1'b0;
    chk("ss_busy", 32'(bus.busy), 0);
    chk("ss_done", 32'(bus.done), 0);
    chk("ss_count", 32'(bus.count), 0);
    chk("ss_expire", 32'(bus.expire_cnt), 0);

    // 300 expiries: expire_cnt saturates at 255.
    bus.load_val = 8'd1; bus.periodic = 1'b1;
    for (int k = 1; k <= 300; k++) push(k, (k > 255) ? 255 : k);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (300) @(negedge clk);
    chk("sat_expire", 32'(bus.expire_cnt), 255);
    chk("sat_busy", 32'(bus.busy), 1);
    pulse_stop();

    // Async reset mid-count: immediate clear, no pulse afterwards.
    bus.load_val = 8'd10; bus.periodic = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 arst_n = 1'b0;
    #1;
    chk("arst_count", 32'(bus.count), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_tc", 32'(bus.tc_pulse), 0);
    @(negedge clk);
    arst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("arst_after_busy", 32'(bus.busy), 0);
    chk("arst_after_done", 32'(bus.done), 0);

`ifdef SMART_DOWN_TIMER_PRESCALER_EN
    // Prescale 2, load 4: expiry 12 cycles after start.
    bus.prescale = 4'd2;
    bus.load_val = 8'd4; bus.periodic = 1'b0;
    push(12, 1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("psc_count_start", 32'(bus.count), 4);
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      chk("psc_count", 32'(bus.count), 4 - (j / 3));
    end
    chk("psc_done", 32'(bus.done), 1);
    // Pause mid-phase: prescale phase is kept, so expiry moves by exactly 4.
    push(16, 2);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.pause = 1'b1;
    repeat (3) @(negedge clk);
    bus.pause = 1'b0;
    repeat (9) @(negedge clk);
    chk("psc_pz_done", 32'(bus.done), 1);
    bus.prescale = 4'd0;
`endif

    repeat (3) @(negedge clk);
    chk("pending_tc", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/smart_down_timer.md
Name: smart_down_timer

Overview:
Loadable down-counting timer; the consuming counterpart of the team's loadable up-counter. Software/control logic arms it with a count value. It decrements to zero, then flags expiry as a one-cycle pulse, in either one-shot or periodic (auto-reload) mode. Used as the timeout and interval generator next to the event counters in the control datapath.

Parameters:
WIDTH, 8, width of load value and live count
EXP_W, 8, width of saturating expiry counter

Ports:
clk  input  1  system clock, rising edge
arst_n  input  1  asynchronous active-low reset
start  input  1  arm/re-arm pulse; captures load_val
stop  input  1  abort; return to IDLE
pause  input  1  level; freeze countdown while high in RUN
periodic  input  1  sampled at start: 1 = auto-reload, 0 = one-shot
load_val  input  WIDTH  initial/reload count (ticks to expiry)
count  output  WIDTH  live remaining count
busy  output  1  high in RUN or PAUSE
done  output  1  level, high in DONE (one-shot expired)
tc_pulse  output  1  one-cycle pulse on each expiry
expire_cnt  output  EXP_W  saturating number of expiries

Behaviour:
- Reset: clk is the clock; reset arst_n is asynchronous, active-low. On reset: state IDLE, count=0, busy=0, done=0, tc_pulse=0, expire_cnt=0, internal reload_reg=0, mode_reg=0.
- All outputs registered; busy/done decoded from the state register.
- States: IDLE, RUN, PAUSE, DONE.
- Input priority each cycle: stop > start > pause > tick.
- stop (any state): next state IDLE, count<=0, expire_cnt<=0, tc_pulse<=0.
- start (any state, stop low):
  - reload_reg<=load_val, count<=load_val, mode_reg<=periodic, next state RUN.
  - Re-arm from RUN/PAUSE/DONE is legal; it discards the remaining count.
  - expire_cnt is unchanged.
- start with load_val==0: immediate expiry. Next cycle tc_pulse=1, state DONE regardless of periodic, expire_cnt+1.
- RUN, tick active, count>1: count<=count-1.
- RUN, tick active, count==1: expiry.
  - tc_pulse<=1 for exactly one cycle.
  - expire_cnt<=expire_cnt+1, saturating at 2^EXP_W-1.
  - mode_reg=1: count<=reload_reg, stay RUN.
  - mode_reg=0: count<=0, go to DONE.
- Period: load_val=N gives tc_pulse N ticks after the start edge. Periodic mode pulses every N ticks.
- RUN with pause=1 -> PAUSE; count holds. PAUSE with pause=0 -> RUN; countdown resumes on the next tick.
- DONE: count=0, done=1, holds until start or stop.
- tc_pulse is low in every cycle that is not an expiry cycle.
- Async reset mid-count returns immediately to reset values; no pulse is generated.
- Tick: every clk cycle, unless the optional prescaler is enabled.

Optional Feature:
Macro SMART_DOWN_TIMER_PRESCALER_EN.
- Defined:
  - Adds input port prescale (4 bits) and an internal 4-bit prescale counter.
  - The prescale counter is cleared on start, stop and reset, and increments in RUN only.
  - Tick is asserted when prescale counter == prescale; the counter then wraps to 0.
  - One countdown step therefore takes prescale+1 cycles; prescale=0 equals no prescaling.
  - The prescale counter holds in PAUSE.
- Undefined: no prescale port, no prescale logic; tick=1 every cycle in RUN.

Test Plan:
- Reset with load_val=8'h05, start held high during reset -> after release: count=0, busy=0, done=0, expire_cnt=0.
- One-shot: load_val=5, periodic=0, start pulse -> count 5,4,3,2,1,0. tc_pulse high exactly once, 5 cycles after the start edge. Then done=1, busy=0, expire_cnt=1.
- Periodic: load_val=3, periodic=1, run 12 cycles -> tc_pulse every 3 cycles (4 pulses), count reloads to 3, expire_cnt=4, done stays 0. Then stop -> IDLE, count=0, expire_cnt=0.
- Pause/restart: load_val=10, pause high for 4 cycles at count=6 -> count holds 6, then resumes. A start with load_val=2 at count=4 -> count=2, expiry 2 cycles later; expire_cnt=1.
- Edge cases:
  - load_val=0 with start -> tc_pulse next cycle, DONE.
  - start and stop in the same cycle -> IDLE.
  - 300 expiries with EXP_W=8 -> expire_cnt saturates at 255.
- With SMART_DOWN_TIMER_PRESCALER_EN, prescale=2, load_val=4 -> tc_pulse 12 cycles after start. With pause, the prescale counter holds its value.
